// File: rtl/hazard_fwd_ctrl_pkg.sv
// rtl/hazard_fwd_ctrl_pkg.sv - shared select encodings, result classes and Tnew helpers
package hazard_fwd_ctrl_pkg;

  // Result class of the instruction occupying a stage
  localparam logic [2:0] SRC_ALU = 3'd0;
  localparam logic [2:0] SRC_DM  = 3'd1;
  localparam logic [2:0] SRC_PC  = 3'd2;
  localparam logic [2:0] SRC_HI  = 3'd3;
  localparam logic [2:0] SRC_LO  = 3'd4;
  localparam logic [2:0] SRC_CP0 = 3'd5;

  // Tuse value meaning "this operand is not read"
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // D/E stage mux select codes (4-bit)
  localparam logic [3:0] SEL_NONE  = 4'd0;
  localparam logic [3:0] SEL_M_ALU = 4'd1;
  localparam logic [3:0] SEL_M_PC  = 4'd2;
  localparam logic [3:0] SEL_M_HI  = 4'd3;
  localparam logic [3:0] SEL_M_LO  = 4'd4;
  localparam logic [3:0] SEL_W_ALU = 4'd5;
  localparam logic [3:0] SEL_W_DM  = 4'd6;
  localparam logic [3:0] SEL_W_PC  = 4'd7;
  localparam logic [3:0] SEL_W_HI  = 4'd8;
  localparam logic [3:0] SEL_W_LO  = 4'd9;
  localparam logic [3:0] SEL_W_CP0 = 4'd10;

  // M stage mux select codes (3-bit, W sources only)
  localparam logic [2:0] SELM_NONE  = 3'd0;
  localparam logic [2:0] SELM_W_ALU = 3'd1;
  localparam logic [2:0] SELM_W_DM  = 3'd2;
  localparam logic [2:0] SELM_W_PC  = 3'd3;
  localparam logic [2:0] SELM_W_HI  = 3'd4;
  localparam logic [2:0] SELM_W_LO  = 3'd5;
  localparam logic [2:0] SELM_W_CP0 = 3'd6;

  // Cycles until the result exists, for an instruction in E
  function automatic logic [1:0] tnew_e(input logic [2:0] src);
    return ((src == SRC_DM) || (src == SRC_CP0)) ? 2'd2 : 2'd1;
  endfunction

  // Cycles until the result exists, for an instruction in M
  function automatic logic [1:0] tnew_m(input logic [2:0] src);
    return ((src == SRC_DM) || (src == SRC_CP0)) ? 2'd1 : 2'd0;
  endfunction

  // Select code for a ready result sitting in M
  function automatic logic [3:0] code_m(input logic [2:0] src);
    case (src)
      SRC_ALU: return SEL_M_ALU;
      SRC_PC:  return SEL_M_PC;
      SRC_HI:  return SEL_M_HI;
      SRC_LO:  return SEL_M_LO;
      default: return SEL_NONE;
    endcase
  endfunction

  // Select code for a result sitting in W
  function automatic logic [3:0] code_w(input logic [2:0] src);
    case (src)
      SRC_ALU: return SEL_W_ALU;
      SRC_DM:  return SEL_W_DM;
      SRC_PC:  return SEL_W_PC;
      SRC_HI:  return SEL_W_HI;
      SRC_LO:  return SEL_W_LO;
      SRC_CP0: return SEL_W_CP0;
      default: return SEL_NONE;
    endcase
  endfunction

  // Fold a 4-bit W-source code onto the 3-bit M-stage encoding
  function automatic logic [2:0] w_to_m(input logic [3:0] code);
    case (code)
      SEL_W_ALU: return SELM_W_ALU;
      SEL_W_DM:  return SELM_W_DM;
      SEL_W_PC:  return SELM_W_PC;
      SEL_W_HI:  return SELM_W_HI;
      SEL_W_LO:  return SELM_W_LO;
      SEL_W_CP0: return SELM_W_CP0;
      default:   return SELM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// rtl/hazard_fwd_ctrl_fwd_sel.sv - one forwarding mux select decoder
module hazard_fwd_ctrl_fwd_sel
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic [4:0] i_reg,
  input  logic [4:0] i_a3_m,
  input  logic [2:0] i_src_m,
  input  logic [4:0] i_a3_w,
  input  logic [2:0] i_src_w,
  input  logic       i_allow_m,
  output logic [3:0] o_sel
);

  logic w_m_hit;
  logic w_w_hit;

  assign w_m_hit = i_allow_m && (i_reg != 5'd0) && (i_a3_m == i_reg);
  assign w_w_hit = (i_reg != 5'd0) && (i_a3_w == i_reg);

  // M is younger and wins; an M match whose value is not ready shadows W (stall covers it)
  always_comb begin
    o_sel = SEL_NONE;
    if (w_m_hit) begin
      if (tnew_m(i_src_m) == 2'd0) o_sel = code_m(i_src_m);
    end else if (w_w_hit) begin
      o_sel = code_w(i_src_w);
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - pipeline hazard, forwarding and MDU busy controller
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic       md_D,
  input  logic       eret_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] rt_M,
  input  logic [4:0] a3_E,
  input  logic [4:0] a3_M,
  input  logic [4:0] a3_W,
  input  logic [2:0] src_E,
  input  logic [2:0] src_M,
  input  logic [2:0] src_W,
  input  logic       mdstart_E,
  input  logic       mdop_E,
  input  logic       mtc0_E,
  input  logic       mtc0_M,
  input  logic [4:0] cp0rd_E,
  input  logic [4:0] cp0rd_M,
  input  logic       flush,
  output logic [3:0] sel_rd1_D,
  output logic [3:0] sel_rd2_D,
  output logic [3:0] sel_alua_E,
  output logic [3:0] sel_alub_E,
  output logic [3:0] sel_memdata_E,
  output logic [2:0] sel_dmwd_M,
  output logic       stall,
  output logic       md_busy
);

  localparam logic [3:0] W_MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] W_DIV_LOAD  = 4'(DIV_CYCLES);
  localparam logic [4:0] CP0_EPC     = 5'd14;

  logic [3:0] r_cnt;
  logic [3:0] w_dmwd_code;
  logic       w_stall_rs;
  logic       w_stall_rt;
  logic       w_stall_md;
  logic       w_stall_eret;

  hazard_fwd_ctrl_fwd_sel u_sel_rd1 (
    .i_reg(rs_D), .i_a3_m(a3_M), .i_src_m(src_M), .i_a3_w(a3_W), .i_src_w(src_W),
    .i_allow_m(1'b1), .o_sel(sel_rd1_D)
  );

  hazard_fwd_ctrl_fwd_sel u_sel_rd2 (
    .i_reg(rt_D), .i_a3_m(a3_M), .i_src_m(src_M), .i_a3_w(a3_W), .i_src_w(src_W),
    .i_allow_m(1'b1), .o_sel(sel_rd2_D)
  );

  hazard_fwd_ctrl_fwd_sel u_sel_alua (
    .i_reg(rs_E), .i_a3_m(a3_M), .i_src_m(src_M), .i_a3_w(a3_W), .i_src_w(src_W),
    .i_allow_m(1'b1), .o_sel(sel_alua_E)
  );

  hazard_fwd_ctrl_fwd_sel u_sel_alub (
    .i_reg(rt_E), .i_a3_m(a3_M), .i_src_m(src_M), .i_a3_w(a3_W), .i_src_w(src_W),
    .i_allow_m(1'b1), .o_sel(sel_alub_E)
  );

  // Store data in E reads the same register as ALU B, so it shares that select
  assign sel_memdata_E = sel_alub_E;

  // The store in M can only be fed from W; the M inputs are masked off
  hazard_fwd_ctrl_fwd_sel u_sel_dmwd (
    .i_reg(rt_M), .i_a3_m(a3_M), .i_src_m(src_M), .i_a3_w(a3_W), .i_src_w(src_W),
    .i_allow_m(1'b0), .o_sel(w_dmwd_code)
  );

  assign sel_dmwd_M = w_to_m(w_dmwd_code);

  // Operand needed before the producer in E or M can deliver it
  assign w_stall_rs = (rs_D != 5'd0) &&
                      (((a3_E == rs_D) && (tuse_rs_D < tnew_e(src_E))) ||
                       ((a3_M == rs_D) && (tuse_rs_D < tnew_m(src_M))));
  assign w_stall_rt = (rt_D != 5'd0) &&
                      (((a3_E == rt_D) && (tuse_rt_D < tnew_e(src_E))) ||
                       ((a3_M == rt_D) && (tuse_rt_D < tnew_m(src_M))));

  assign w_stall_md   = md_D && (md_busy || mdstart_E);
  assign w_stall_eret = eret_D && ((mtc0_E && (cp0rd_E == CP0_EPC)) ||
                                   (mtc0_M && (cp0rd_M == CP0_EPC)));

  assign stall = w_stall_rs || w_stall_rt || w_stall_md || w_stall_eret;

  // MDU busy counter: a cancelled issue is ignored, a running op keeps counting through flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (mdstart_E && !flush) begin
      r_cnt <= mdop_E ? W_DIV_LOAD : W_MULT_LOAD;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign md_busy = (r_cnt != 4'd0);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - scoreboard bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

  typedef struct packed {
    logic [3:0] rd1;
    logic [3:0] rd2;
    logic [3:0] alua;
    logic [3:0] alub;
    logic [3:0] memd;
    logic [2:0] dmwd;
    logic       stall;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, rt_M, a3_E, a3_M, a3_W, cp0rd_E, cp0rd_M;
  logic [1:0] tuse_rs_D, tuse_rt_D;
  logic [2:0] src_E, src_M, src_W;
  logic       md_D, eret_D, mdstart_E, mdop_E, mtc0_E, mtc0_M, flush;
  logic [3:0] sel_rd1_D, sel_rd2_D, sel_alua_E, sel_alub_E, sel_memdata_E;
  logic [2:0] sel_dmwd_M;
  logic       stall, md_busy;

  exp_t  q_exp[$];
  string q_nm[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .md_D(md_D), .eret_D(eret_D),
    .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
    .a3_E(a3_E), .a3_M(a3_M), .a3_W(a3_W),
    .src_E(src_E), .src_M(src_M), .src_W(src_W),
    .mdstart_E(mdstart_E), .mdop_E(mdop_E),
    .mtc0_E(mtc0_E), .mtc0_M(mtc0_M), .cp0rd_E(cp0rd_E), .cp0rd_M(cp0rd_M),
    .flush(flush),
    .sel_rd1_D(sel_rd1_D), .sel_rd2_D(sel_rd2_D),
    .sel_alua_E(sel_alua_E), .sel_alub_E(sel_alub_E), .sel_memdata_E(sel_memdata_E),
    .sel_dmwd_M(sel_dmwd_M), .stall(stall), .md_busy(md_busy)
  );

  function automatic exp_t mk(input logic [3:0] rd1, input logic [3:0] rd2,
                              input logic [3:0] alua, input logic [3:0] alub,
                              input logic [3:0] memd, input logic [2:0] dmwd,
                              input logic st, input logic bz);
    exp_t e;
    e.rd1 = rd1; e.rd2 = rd2; e.alua = alua; e.alub = alub; e.memd = memd;
    e.dmwd = dmwd; e.stall = st; e.busy = bz;
    return e;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle; compare against the oldest pending expectation
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (q_exp.size() > 0) begin
      e  = q_exp.pop_front();
      nm = q_nm.pop_front();
      chk(nm, "sel_rd1_D",     sel_rd1_D,            e.rd1);
      chk(nm, "sel_rd2_D",     sel_rd2_D,            e.rd2);
      chk(nm, "sel_alua_E",    sel_alua_E,           e.alua);
      chk(nm, "sel_alub_E",    sel_alub_E,           e.alub);
      chk(nm, "sel_memdata_E", sel_memdata_E,        e.memd);
      chk(nm, "sel_dmwd_M",    {1'b0, sel_dmwd_M},   {1'b0, e.dmwd});
      chk(nm, "stall",         {3'b000, stall},      {3'b000, e.stall});
      chk(nm, "md_busy",       {3'b000, md_busy},    {3'b000, e.busy});
    end
  end

  task automatic clr();
    rs_D = 0; rt_D = 0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; md_D = 0; eret_D = 0;
    rs_E = 0; rt_E = 0; rt_M = 0; a3_E = 0; a3_M = 0; a3_W = 0;
    src_E = 0; src_M = 0; src_W = 0; mdstart_E = 0; mdop_E = 0;
    mtc0_E = 0; mtc0_M = 0; cp0rd_E = 0; cp0rd_M = 0; flush = 0;
  endtask

  // Inputs are already applied for this cycle; queue the expectation and advance
  task automatic cyc(input string nm, input exp_t e);
    q_exp.push_back(e);
    q_nm.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    @(posedge clk); #1;
    cyc("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // addu $1 in M, beq $1,$2 in D
    clr(); rs_D = 1; rt_D = 2; tuse_rs_D = 0; tuse_rt_D = 0; a3_M = 1; src_M = 0;
    cyc("addu_M_beq", mk(1, 0, 0, 0, 0, 0, 0, 0));
    // lw $1 in M: not ready, stall
    src_M = 1;
    cyc("lw_M_beq", mk(0, 0, 0, 0, 0, 0, 1, 0));
    // lw in M shadows an older ALU write of $1 in W
    a3_W = 1; src_W = 0;
    cyc("lw_M_shadow_W", mk(0, 0, 0, 0, 0, 0, 1, 0));
    // lw now in W
    a3_M = 0; src_M = 0; a3_W = 1; src_W = 1;
    cyc("lw_W_beq", mk(6, 0, 0, 0, 0, 0, 0, 0));

    // jal then jr $31
    clr(); rs_D = 31; tuse_rs_D = 0; a3_M = 31; src_M = 2;
    cyc("jal_M_jr", mk(2, 0, 0, 0, 0, 0, 0, 0));
    a3_M = 0; src_M = 0; a3_W = 31; src_W = 2;
    cyc("jal_W_jr", mk(7, 0, 0, 0, 0, 0, 0, 0));

    // sw rt=$2 in E, mfc0 $2 in W
    clr(); rs_E = 29; rt_E = 2; a3_W = 2; src_W = 5;
    cyc("sw_E_mfc0_W", mk(0, 0, 0, 10, 10, 0, 0, 0));
    // store in M from mfc0 in W; a matching M write must not reach the M mux
    clr(); rt_M = 3; a3_W = 3; src_W = 5; a3_M = 3; src_M = 0;
    cyc("sw_M_mfc0_W", mk(0, 0, 0, 0, 0, 6, 0, 0));
    clr(); rt_M = 8; a3_W = 8; src_W = 1;
    cyc("sw_M_lw_W", mk(0, 0, 0, 0, 0, 2, 0, 0));

    // mfhi $4 in M beats a write of $4 in W, for E and D sources
    clr(); rs_E = 4; rt_E = 4; rt_D = 4; tuse_rt_D = 1; a3_M = 4; src_M = 3; a3_W = 4; src_W = 4;
    cyc("mfhi_M_prio", mk(0, 3, 3, 3, 3, 0, 0, 0));
    // mflo $7 in W feeding both D operands
    clr(); rs_D = 7; rt_D = 7; tuse_rs_D = 1; tuse_rt_D = 2; a3_W = 7; src_W = 4;
    cyc("mflo_W_both", mk(9, 9, 0, 0, 0, 0, 0, 0));

    // producer in E vs Tuse
    clr(); rs_D = 6; tuse_rs_D = 0; a3_E = 6; src_E = 0;
    cyc("alu_E_tuse0", mk(0, 0, 0, 0, 0, 0, 1, 0));
    tuse_rs_D = 1;
    cyc("alu_E_tuse1", mk(0, 0, 0, 0, 0, 0, 0, 0));
    src_E = 1;
    cyc("lw_E_tuse1", mk(0, 0, 0, 0, 0, 0, 1, 0));
    clr(); rt_D = 6; tuse_rt_D = 2; a3_E = 6; src_E = 1;
    cyc("lw_E_tuse2", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // $0 writes never forward or stall
    clr(); tuse_rs_D = 0; tuse_rt_D = 0; a3_E = 0; src_E = 1; a3_M = 0; src_M = 0; a3_W = 0; src_W = 1;
    cyc("zero_reg", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // eret after mtc0
    clr(); eret_D = 1; mtc0_E = 1; cp0rd_E = 14;
    cyc("eret_mtc0_epc_E", mk(0, 0, 0, 0, 0, 0, 1, 0));
    cp0rd_E = 12;
    cyc("eret_mtc0_sr_E", mk(0, 0, 0, 0, 0, 0, 0, 0));
    clr(); eret_D = 1; mtc0_M = 1; cp0rd_M = 14;
    cyc("eret_mtc0_epc_M", mk(0, 0, 0, 0, 0, 0, 1, 0));

    // mult issues, mflo waits in D: 1 + 5 stall cycles
    clr(); md_D = 1; mdstart_E = 1; mdop_E = 0;
    cyc("mult_issue", mk(0, 0, 0, 0, 0, 0, 1, 0));
    mdstart_E = 0;
    for (int i = 0; i < 5; i++) cyc("mult_busy", mk(0, 0, 0, 0, 0, 0, 1, 1));
    cyc("mult_done", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // div issues, async reset while count is 4
    clr(); mdstart_E = 1; mdop_E = 1;
    cyc("div_issue", mk(0, 0, 0, 0, 0, 0, 0, 0));
    mdstart_E = 0;
    for (int i = 0; i < 6; i++) cyc("div_busy", mk(0, 0, 0, 0, 0, 0, 0, 1));
    reset = 1'b1;
    cyc("div_reset_mid", mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    cyc("div_after_reset", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // div cancelled by flush in the issue cycle
    clr(); mdstart_E = 1; mdop_E = 1; flush = 1; md_D = 1;
    cyc("div_flush_issue", mk(0, 0, 0, 0, 0, 0, 1, 0));
    clr(); md_D = 1;
    cyc("div_flush_after", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // flush does not cancel a running mult
    clr(); mdstart_E = 1;
    cyc("mult2_issue", mk(0, 0, 0, 0, 0, 0, 0, 0));
    clr(); flush = 1;
    cyc("mult2_flush", mk(0, 0, 0, 0, 0, 0, 0, 1));
    clr();
    for (int i = 0; i < 4; i++) cyc("mult2_busy", mk(0, 0, 0, 0, 0, 0, 0, 1));
    cyc("mult2_done", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // reissue while busy reloads: mult then div, busy for the full div length
    clr(); mdstart_E = 1;
    cyc("reload_mult", mk(0, 0, 0, 0, 0, 0, 0, 0));
    mdop_E = 1;
    cyc("reload_div", mk(0, 0, 0, 0, 0, 0, 0, 1));
    clr();
    for (int i = 0; i < 10; i++) cyc("reload_busy", mk(0, 0, 0, 0, 0, 0, 0, 1));
    cyc("reload_done", mk(0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clk); #1;
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
